seven_segment_mux: RTL and testbench
====================================

SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIGIT_PERIOD, default 100000: clock cycles each digit is driven; legal minimum 2.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data  input  4*NUM_DIGITS  hex nibbles; nibble k (data[4k+3:4k]) is shown on digit k, where digit 0 is least significant.
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-007 blank  input  NUM_DIGITS  per-digit blank request, 1 = all segments off.
REQ-008 load  input  1  single-cycle strobe that captures data, dp_in and blank.
REQ-009 anode  output  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high.
REQ-010 segment  output  7  segments a..g on bits 0..6, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 update_pending  output  1  1 = a captured value is waiting for the frame boundary.

Function
REQ-013 The block shall keep two register sets: pending (written by load) and display (drives the outputs).
REQ-014 load = 1 shall write data, dp_in and blank into pending and set update_pending on the next edge; a later load before the copy shall overwrite pending.
REQ-015 A cycle counter shall run 0..DIGIT_PERIOD-1 and wrap to 0; at the wrap, the digit index shall advance by one.
REQ-016 The digit index shall wrap from NUM_DIGITS-1 to 0; that edge is the frame boundary.
REQ-017 At the frame boundary with update_pending = 1, pending shall be copied to display and update_pending shall be cleared.
REQ-018 If load and the frame boundary occur in the same cycle, the load values shall go directly to display, and update_pending shall be 0 afterwards.
REQ-019 anode, segment and dp shall be registered; the output for digit k shall appear one cycle after the index becomes k.
REQ-020 During the first cycle of every digit slot (counter = 0), the anode outputs shall be all 1 (ghost suppression).
REQ-021 For counter ≥ 1, anode[k] shall be 0 only for the current index k; segment shall be the standard hex glyph (0-9, A, b, C, d, E, F) of display nibble k.
REQ-022 A set blank bit shall force segment = 7'h7F and dp = 1 for that digit.
REQ-023 With NUM_DIGITS = 1, the index shall stay 0, and every counter wrap shall be a frame boundary.

Reset
REQ-024 While rst_n = 0: counter 0, index 0, pending and display 0, update_pending 0, anode all 1, segment 7'h7F, dp 1.
REQ-025 After rst_n deasserts, scanning shall start from digit 0 with counter 0; a load lost to a mid-operation reset shall not be recovered.

Configuration
REQ-026 With SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN defined, display digits from NUM_DIGITS-1 downward shall be blanked while their nibble is 0, up to the first non-zero nibble.
REQ-027 Under that macro, digit 0 shall never be zero-blanked, and dp on a zero-blanked digit shall still follow dp_in.
REQ-028 Without the macro, only the blank input shall blank digits.

Structure
REQ-029 Package seven_segment_pkg shall hold: seg_t (logic [6:0]), SEG_OFF = 7'h7F, and function hex_to_seg (nibble to active-low glyph).
REQ-030 Counter and index generation shall be in sub-module digit_scan_timer (parameters NUM_DIGITS, DIGIT_PERIOD; outputs index, slot_start, frame_wrap).
REQ-031 Illegal parameter values shall be rejected at elaboration.

Verification
REQ-032 Reset mid-frame: NUM_DIGITS=4, DIGIT_PERIOD=4, pull rst_n low -> anode=4'hF, segment=7'h7F, dp=1 immediately, without waiting for a clock edge.
REQ-033 Scan order: load data=16'h12AF -> after the next frame boundary, digits 0..3 show 7'h0E, 7'h08, 7'h24, 7'h79, each for 3 cycles after one all-off cycle.
REQ-034 Coincident events: load 16'h0005 on the frame-boundary cycle -> update_pending stays 0, and digit 0 shows 7'h12 in the next frame.
REQ-035 Double load: load 16'h1111 and then 16'h2222 within one frame -> only 2222 is displayed; update_pending=1 until the boundary.
REQ-036 Zero suppression with the macro: data=16'h0070, dp_in=4'b1000 -> digit 3 segment=7'h7F with dp=0; digit 2 7'h7F; digit 1 7'h78; digit 0 7'h40.
REQ-037 Zero suppression without the macro: same stimulus -> digits 3 and 2 show 7'h40.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and the hex glyph table for the seven-segment display mux.
// Segments are active-low, a..g on bits 0..6.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_scan_timer.sv
// Per-digit slot counter and digit index for the display scan.
// Ports: clk, rst_n; index (current digit), slot_start (counter == 0),
// frame_wrap (high in the cycle whose edge wraps the index to 0).
module digit_scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 100000,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(DIGIT_PERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] index,
    output logic          slot_start,
    output logic          frame_wrap
);

    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic          w_last_cyc;
    logic          w_last_dig;

    assign w_last_cyc = (r_cnt == CW'(DIGIT_PERIOD - 1));
    assign w_last_dig = (r_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_last_cyc) begin
            r_cnt <= '0;
            r_idx <= w_last_dig ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign index      = r_idx;
    assign slot_start = (r_cnt == '0);
    assign frame_wrap = w_last_cyc & w_last_dig;

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver with frame-synchronous display update.
// Ports: clk, rst_n, data/dp_in/blank/load in; anode, segment, dp,
// update_pending out (all display outputs active-low).
// Option: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic                    update_pending
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be 1..8");
    end
    if (DIGIT_PERIOD < 2) begin : g_bad_period
        $error("DIGIT_PERIOD must be >= 2");
    end

    logic [IW-1:0] w_idx;
    logic          w_slot_start;
    logic          w_frame_wrap;

    digit_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIGIT_PERIOD(DIGIT_PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (w_idx),
        .slot_start(w_slot_start),
        .frame_wrap(w_frame_wrap)
    );

    logic [4*NUM_DIGITS-1:0] r_pend_data, r_disp_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_disp_blank;
    logic                    r_pending;

    // A load landing on the frame boundary bypasses pending entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_pending    <= 1'b0;
        end else if (load && w_frame_wrap) begin
            r_disp_data  <= data;
            r_disp_dp    <= dp_in;
            r_disp_blank <= blank;
            r_pending    <= 1'b0;
        end else if (load) begin
            r_pend_data  <= data;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank;
            r_pending    <= 1'b1;
        end else if (w_frame_wrap && r_pending) begin
            r_disp_data  <= r_pend_data;
            r_disp_dp    <= r_pend_dp;
            r_disp_blank <= r_pend_blank;
            r_pending    <= 1'b0;
        end
    end

    logic [NUM_DIGITS-1:0] w_zblank;

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic w_run;
    // Walk down from the top digit while nibbles stay zero; digit 0 never.
    always_comb begin
        w_zblank = '0;
        w_run    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run       = w_run && (r_disp_data[4*k +: 4] == 4'h0);
            w_zblank[k] = w_run;
        end
    end
`else
    assign w_zblank = '0;
`endif

    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_blk_sel;
    logic                  w_zb_sel;
    logic [NUM_DIGITS-1:0] w_anode;

    always_comb begin
        w_nib     = 4'h0;
        w_dp_sel  = 1'b0;
        w_blk_sel = 1'b0;
        w_zb_sel  = 1'b0;
        w_anode   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx == IW'(k)) begin
                w_nib      = r_disp_data[4*k +: 4];
                w_dp_sel   = r_disp_dp[k];
                w_blk_sel  = r_disp_blank[k];
                w_zb_sel   = w_zblank[k];
                w_anode[k] = 1'b0;
            end
        end
    end

    logic [NUM_DIGITS-1:0] r_anode;
    seg_t                  r_seg;
    logic                  r_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else if (w_slot_start) begin
            r_anode <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_anode;
            if (w_blk_sel) begin
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else if (w_zb_sel) begin
                r_seg <= SEG_OFF;
                r_dp  <= ~w_dp_sel;
            end else begin
                r_seg <= hex_to_seg(w_nib);
                r_dp  <= ~w_dp_sel;
            end
        end
    end

    assign anode          = r_anode;
    assign segment        = r_seg;
    assign dp             = r_dp;
    assign update_pending = r_pending;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux (4 digits, 4-cycle slots).
// Reference model tracks time since reset and applies the frame rules.
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int DP = 4;
    localparam int FRAME = ND * DP;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank = '0;
    logic          load = 1'b0;
    logic [3:0]    anode;
    logic [6:0]    segment;
    logic          dp;
    logic          update_pending;

    seven_segment_mux #(
        .NUM_DIGITS  (ND),
        .DIGIT_PERIOD(DP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data          (data),
        .dp_in         (dp_in),
        .blank         (blank),
        .load          (load),
        .anode         (anode),
        .segment       (segment),
        .dp            (dp),
        .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          t;
    logic [15:0] m_pd, m_dd;
    logic [3:0]  m_pdp, m_ddp, m_pbl, m_dbl;
    bit          m_flag;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit zb(input logic [15:0] d, input int k);
        int top;
        top = -1;
        for (int i = 0; i < ND; i++)
            if (d[4*i +: 4] != 4'h0) top = i;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        return (k > 0) && (k > top);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        t = 0;
        m_pd = '0; m_dd = '0;
        m_pdp = '0; m_ddp = '0;
        m_pbl = '0; m_dbl = '0;
        m_flag = 1'b0;
    endtask

    task automatic step(input bit ld, input logic [15:0] d,
                        input logic [3:0] dpi, input logic [3:0] bl);
        int          cnt, idx;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        bit          bnd;
        @(negedge clk);
        load = ld; data = d; dp_in = dpi; blank = bl;
        cnt = t % DP;
        idx = (t / DP) % ND;
        e_an = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
        if (m_dbl[idx]) begin
            e_seg = 7'h7F; e_dp = 1'b1;
        end else if (zb(m_dd, idx)) begin
            e_seg = 7'h7F; e_dp = ~m_ddp[idx];
        end else begin
            e_seg = GLYPH[m_dd[4*idx +: 4]]; e_dp = ~m_ddp[idx];
        end
        @(posedge clk);
        bnd = (t % FRAME) == FRAME - 1;
        if (ld && bnd) begin
            m_dd = d; m_ddp = dpi; m_dbl = bl; m_flag = 1'b0;
        end else if (ld) begin
            m_pd = d; m_pdp = dpi; m_pbl = bl; m_flag = 1'b1;
        end else if (bnd && m_flag) begin
            m_dd = m_pd; m_ddp = m_pdp; m_dbl = m_pbl; m_flag = 1'b0;
        end
        t++;
        #1;
        chk("anode", 32'(anode), 32'(e_an));
        if (cnt != 0) begin
            chk("segment", 32'(segment), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
        end
        chk("update_pending", 32'(update_pending), 32'(m_flag));
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, data, dp_in, blank);
    endtask

    task automatic ld(input logic [15:0] d, input logic [3:0] dpi,
                      input logic [3:0] bl);
        step(1'b1, d, dpi, bl);
    endtask

    task automatic align(input int r);
        for (int i = 0; i < FRAME && (t % FRAME) != r; i++)
            step(1'b0, data, dp_in, blank);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_anode"}, 32'(anode), 32'hF);
        chk({tag, "_segment"}, 32'(segment), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'h1);
        chk({tag, "_pending"}, 32'(update_pending), 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // Scan order with 12AF
        ld(16'h12AF, 4'h0, 4'h0);
        chk("scan_pend", 32'(update_pending), 32'h1);
        align(0);
        run(2);
        chk("scan_d0", 32'(segment), 32'h0E);
        run(4);
        chk("scan_d1", 32'(segment), 32'h08);
        run(4);
        chk("scan_d2", 32'(segment), 32'h24);
        run(4);
        chk("scan_d3", 32'(segment), 32'h79);
        chk("scan_an3", 32'(anode), 32'h7);

        // Load coincident with the frame boundary
        align(FRAME - 1);
        ld(16'h0005, 4'h0, 4'h0);
        chk("coinc_pend", 32'(update_pending), 32'h0);
        run(2);
        chk("coinc_d0", 32'(segment), 32'h12);
        chk("coinc_an0", 32'(anode), 32'hE);

        // Two loads in one frame: only the last shows
        align(1);
        ld(16'h1111, 4'h0, 4'h0);
        run(3);
        ld(16'h2222, 4'h0, 4'h0);
        chk("dbl_pend", 32'(update_pending), 32'h1);
        align(0);
        chk("dbl_pend_clr", 32'(update_pending), 32'h0);
        run(2);
        chk("dbl_d0", 32'(segment), 32'h24);

        // Leading zeros
        ld(16'h0070, 4'b1000, 4'h0);
        align(0);
        run(6);
        chk("lz_d1", 32'(segment), 32'h78);
        run(4);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        chk("lz_d2", 32'(segment), 32'h7F);
`else
        chk("lz_d2", 32'(segment), 32'h40);
`endif
        run(4);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        chk("lz_d3", 32'(segment), 32'h7F);
`else
        chk("lz_d3", 32'(segment), 32'h40);
`endif
        chk("lz_d3_dp", 32'(dp), 32'h0);

        // Random loads, blanks and decimal points
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0)
                ld(16'($urandom), 4'($urandom),
                   ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0);
            else
                run(1);
        end

        // Asynchronous reset in mid-frame, with a load just lost
        align(6);
        ld(16'hBEEF, 4'hF, 4'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(negedge clk);
        release_reset();
        run(FRAME + 2);
        chk("post_rst_d0", 32'(segment), 32'h40);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(5) == 0)
                ld(16'($urandom), 4'($urandom),
                   ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0);
            else
                run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
